// File: rtl/mem_pkg.sv
// Shared opcodes, FSM encoding, byte-enable constants and opcode classifiers
// for the MEM-stage data-memory access unit.
package mem_pkg;

   localparam logic [4:0] OP_LB  = 5'h10;
   localparam logic [4:0] OP_LBU = 5'h11;
   localparam logic [4:0] OP_LH  = 5'h12;
   localparam logic [4:0] OP_LHU = 5'h13;
   localparam logic [4:0] OP_LW  = 5'h14;
   localparam logic [4:0] OP_SB  = 5'h15;
   localparam logic [4:0] OP_SH  = 5'h16;
   localparam logic [4:0] OP_SW  = 5'h17;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_REQ  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;

   function automatic logic is_mem_op(input logic [4:0] op);
      return (op >= OP_LB) && (op <= OP_SW);
   endfunction

   function automatic logic is_load(input logic [4:0] op);
      return (op >= OP_LB) && (op <= OP_LW);
   endfunction

   function automatic logic is_store(input logic [4:0] op);
      return (op >= OP_SB) && (op <= OP_SW);
   endfunction

   // Halfword ops need an even address, word ops a multiple of four.
   function automatic logic is_misaligned(input logic [4:0] op, input logic [1:0] addr_lo);
      logic mis;
      case (op)
         OP_LH, OP_LHU, OP_SH: mis = addr_lo[0];
         OP_LW, OP_SW:         mis = |addr_lo;
         default:              mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_access_lane_align.sv
// Combinational lane steering: little-endian load extraction with sign/zero
// extension, and store-data replication with byte enables.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [4:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_src,
   input  logic [31:0] load_word,
   output logic [31:0] load_data,
   output logic [31:0] store_data,
   output logic [3:0]  byte_en,
   output logic        write_en
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_s = load_word[7:0];
         2'd1:    byte_s = load_word[15:8];
         2'd2:    byte_s = load_word[23:16];
         2'd3:    byte_s = load_word[31:24];
         default: byte_s = load_word[7:0];
      endcase
      if (addr_lo[1]) begin
         half_s = load_word[31:16];
      end else begin
         half_s = load_word[15:0];
      end
   end

   always_comb begin
      case (op)
         OP_LB:   load_data = {{24{byte_s[7]}}, byte_s};
         OP_LBU:  load_data = {24'h00_0000, byte_s};
         OP_LH:   load_data = {{16{half_s[15]}}, half_s};
         OP_LHU:  load_data = {16'h0000, half_s};
         default: load_data = load_word;
      endcase
   end

   // Loads and non-memory ops present a full-word read enable pattern.
   always_comb begin
      case (op)
         OP_SB: begin
            store_data = {4{store_src[7:0]}};
            byte_en    = BE_BYTE0 << addr_lo;
         end
         OP_SH: begin
            store_data = {2{store_src[15:0]}};
            byte_en    = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
         end
         default: begin
            store_data = store_src;
            byte_en    = BE_WORD;
         end
      endcase
   end

   assign write_en = is_store(op);

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-memory access unit: req/ack bus FSM with timeout, pipeline
// stall request and write-back muxing toward the MEM/WB register.
module mem_access
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  memALUop,
   input  logic [31:0] memAddr,
   input  logic [31:0] memReg,
   input  logic [4:0]  memWriteNum,
   input  logic        memWriteReg,
   input  logic [31:0] memWriteData,
   output logic [4:0]  wbWriteNum,
   output logic        wbWriteReg,
   output logic [31:0] wbWriteData,
   output logic        stallReq,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   input  logic        dm_ack,
   output logic        misalignExc,
   output logic        busErr
);

   localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 32'd0) ? CNT_W'(TIMEOUT_CYCLES - 32'd1) : '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [31:0]      load_r;
   logic             abort_r;
   logic             bus_err_r;
   logic             req_r;
   logic             we_r;
   logic [31:0]      addr_r;
   logic [3:0]       be_r;
   logic [31:0]      wdata_r;

   logic             mem_op_s;
   logic             misal_s;
   logic             start_s;
   logic             timeout_s;
   logic [31:0]      load_data_s;
   logic [31:0]      store_data_s;
   logic [3:0]       byte_en_s;
   logic             write_en_s;

   mem_lane_align u_align (
      .op         (memALUop),
      .addr_lo    (memAddr[1:0]),
      .store_src  (memReg),
      .load_word  (load_r),
      .load_data  (load_data_s),
      .store_data (store_data_s),
      .byte_en    (byte_en_s),
      .write_en   (write_en_s)
   );

   assign mem_op_s  = is_mem_op(memALUop);
   assign misal_s   = is_misaligned(memALUop, memAddr[1:0]);
   assign start_s   = (state_r == ST_IDLE) && mem_op_s && !misal_s;
   assign timeout_s = (TIMEOUT_CYCLES != 32'd0) && (cnt_r == CNT_LAST);

   // Bus FSM; an ack in the final allowed REQ cycle wins over the timeout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         load_r    <= 32'h0000_0000;
         abort_r   <= 1'b0;
         bus_err_r <= 1'b0;
         req_r     <= 1'b0;
         we_r      <= 1'b0;
         addr_r    <= 32'h0000_0000;
         be_r      <= 4'b0000;
         wdata_r   <= 32'h0000_0000;
      end else begin
         bus_err_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  state_r <= ST_REQ;
                  cnt_r   <= '0;
                  abort_r <= 1'b0;
                  req_r   <= 1'b1;
                  we_r    <= write_en_s;
                  addr_r  <= {memAddr[31:2], 2'b00};
                  be_r    <= byte_en_s;
                  wdata_r <= store_data_s;
               end
            end
            ST_REQ: begin
               if (dm_ack) begin
                  load_r  <= dm_rdata;
                  req_r   <= 1'b0;
                  state_r <= ST_DONE;
               end else if (timeout_s) begin
                  req_r     <= 1'b0;
                  abort_r   <= 1'b1;
                  bus_err_r <= 1'b1;
                  state_r   <= ST_DONE;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               req_r   <= 1'b0;
            end
         endcase
      end
   end

   // Write-back muxing and stall; stall/exception are gated while reset is asserted.
   always_comb begin
      wbWriteNum  = memWriteNum;
      wbWriteData = memWriteData;
      wbWriteReg  = memWriteReg;
      stallReq    = 1'b0;
      misalignExc = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               stallReq   = rst;
               wbWriteReg = 1'b0;
            end else if (mem_op_s) begin
               misalignExc = rst;
               wbWriteReg  = 1'b0;
            end else begin
               wbWriteReg = memWriteReg;
            end
         end
         ST_REQ: begin
            stallReq   = rst;
            wbWriteReg = 1'b0;
         end
         ST_DONE: begin
            if (abort_r || !is_load(memALUop)) begin
               wbWriteReg = 1'b0;
            end else begin
               wbWriteData = load_data_s;
               wbWriteReg  = memWriteReg;
            end
         end
         default: begin
            wbWriteReg = 1'b0;
         end
      endcase
   end

   assign dm_req   = req_r;
   assign dm_we    = we_r;
   assign dm_addr  = addr_r;
   assign dm_be    = be_r;
   assign dm_wdata = wdata_r;
   assign busErr   = bus_err_r;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: randomized loads/stores against a
// behavioural lane/extension model, plus directed timeout and reset cases.
module tb_mem_access;

   logic        clk;
   logic        rst;
   logic [4:0]  memALUop;
   logic [31:0] memAddr;
   logic [31:0] memReg;
   logic [4:0]  memWriteNum;
   logic        memWriteReg;
   logic [31:0] memWriteData;
   logic [4:0]  wbWriteNum;
   logic        wbWriteReg;
   logic [31:0] wbWriteData;
   logic        stallReq;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        misalignExc;
   logic        busErr;

   int n_cmp = 0;
   int n_bad = 0;

   mem_access #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .memALUop(memALUop), .memAddr(memAddr), .memReg(memReg),
      .memWriteNum(memWriteNum), .memWriteReg(memWriteReg), .memWriteData(memWriteData),
      .wbWriteNum(wbWriteNum), .wbWriteReg(wbWriteReg), .wbWriteData(wbWriteData),
      .stallReq(stallReq), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .misalignExc(misalignExc), .busErr(busErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int op_size(input logic [4:0] op);
      if (op == 5'h10 || op == 5'h11 || op == 5'h15) return 1;
      else if (op == 5'h12 || op == 5'h13 || op == 5'h16) return 2;
      else return 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] w);
      logic [31:0] v;
      int unsigned off;
      off = addr % 4;
      if (op == 5'h10 || op == 5'h11) begin
         v = (w >> (8 * off)) & 32'hFF;
         if (op == 5'h10 && v >= 32'd128) v = v - 32'd256;
      end else if (op == 5'h12 || op == 5'h13) begin
         v = (w >> (16 * (off / 2))) & 32'hFFFF;
         if (op == 5'h12 && v >= 32'h8000) v = v - 32'h10000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [4:0] op, input logic [31:0] r);
      int sz;
      sz = op_size(op);
      if (sz == 1) return (r & 32'hFF) * 32'h0101_0101;
      else if (sz == 2) return (r & 32'hFFFF) * 32'h0001_0001;
      else return r;
   endfunction

   function automatic logic [3:0] model_be(input logic [4:0] op, input logic [31:0] addr);
      int sz;
      int unsigned v;
      sz = op_size(op);
      if (op < 5'h15) return 4'hF;
      v = ((32'd1 << sz) - 32'd1) << (addr % 4);
      return v[3:0];
   endfunction

   function automatic logic [31:0] rand_nonmem_op_word();
      logic [31:0] r;
      r = $urandom_range(0, 23);
      if (r >= 32'd16) r = r + 32'd8;
      return r;
   endfunction

   task automatic drive(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] regv,
                        input logic [4:0] num, input logic wr, input logic [31:0] data);
      memALUop = op; memAddr = addr; memReg = regv;
      memWriteNum = num; memWriteReg = wr; memWriteData = data;
   endtask

   task automatic drive_nop();
      drive(5'h00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
   endtask

   // One aligned load/store transaction, ending in its DONE cycle (inputs still held).
   task automatic run_mem_op(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] regv,
                             input logic [31:0] rdata, input int delay, input logic [4:0] num,
                             input logic wr, input logic [31:0] data);
      int stall_cnt;
      int req_cyc;
      logic ld;
      ld = (op <= 5'h14);
      @(negedge clk);
      drive(op, addr, regv, num, wr, data);
      dm_ack = 1'b0;
      #1;
      n_cmp++; if (stallReq !== 1'b1) begin n_bad++; $display("FAIL idle_stall op=%h got %b want 1", op, stallReq); end
      n_cmp++; if (wbWriteReg !== 1'b0) begin n_bad++; $display("FAIL idle_wbreg op=%h got %b want 0", op, wbWriteReg); end
      n_cmp++; if (misalignExc !== 1'b0) begin n_bad++; $display("FAIL idle_misal op=%h got %b want 0", op, misalignExc); end
      stall_cnt = 0;
      req_cyc = 0;
      while (stallReq === 1'b1 && stall_cnt < 20) begin
         stall_cnt++;
         @(negedge clk);
         dm_ack = 1'b0;
         if (dm_req === 1'b1) begin
            if (req_cyc == 0) begin
               n_cmp++; if (dm_addr !== (addr & 32'hFFFF_FFFC)) begin n_bad++; $display("FAIL dm_addr got %h want %h", dm_addr, addr & 32'hFFFF_FFFC); end
               n_cmp++; if (dm_we !== !ld) begin n_bad++; $display("FAIL dm_we op=%h got %b want %b", op, dm_we, !ld); end
               n_cmp++; if (dm_be !== model_be(op, addr)) begin n_bad++; $display("FAIL dm_be op=%h addr=%h got %b want %b", op, addr, dm_be, model_be(op, addr)); end
               if (!ld) begin
                  n_cmp++; if (dm_wdata !== model_wdata(op, regv)) begin n_bad++; $display("FAIL dm_wdata op=%h got %h want %h", op, dm_wdata, model_wdata(op, regv)); end
               end
            end
            if (req_cyc == delay) begin dm_ack = 1'b1; dm_rdata = rdata; end
            req_cyc++;
         end
         #1;
      end
      n_cmp++; if (stall_cnt !== delay + 2) begin n_bad++; $display("FAIL stall_cycles op=%h got %0d want %0d", op, stall_cnt, delay + 2); end
      n_cmp++; if (dm_req !== 1'b0) begin n_bad++; $display("FAIL done_req got %b want 0", dm_req); end
      n_cmp++; if (wbWriteReg !== (ld ? wr : 1'b0)) begin n_bad++; $display("FAIL done_wbreg op=%h got %b want %b", op, wbWriteReg, ld ? wr : 1'b0); end
      n_cmp++; if (wbWriteNum !== num) begin n_bad++; $display("FAIL done_wbnum got %0d want %0d", wbWriteNum, num); end
      if (ld) begin
         // a stray ack in DONE must not disturb the captured data
         dm_ack = 1'b1; dm_rdata = ~rdata;
         #1;
         n_cmp++; if (wbWriteData !== model_load(op, addr, rdata)) begin n_bad++; $display("FAIL load_data op=%h addr=%h got %h want %h", op, addr, wbWriteData, model_load(op, addr, rdata)); end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0; dm_ack = 1'b0; dm_rdata = 32'h0;
      drive(5'h14, 32'h0000_1000, 32'h0, 5'd1, 1'b1, 32'h0);
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (dm_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", dm_req); end
      n_cmp++; if ({dm_we, dm_be, dm_addr, dm_wdata} !== 69'd0) begin n_bad++; $display("FAIL rst_dm got %h want 0", {dm_we, dm_be, dm_addr, dm_wdata}); end
      n_cmp++; if (busErr !== 1'b0) begin n_bad++; $display("FAIL rst_buserr got %b want 0", busErr); end
      n_cmp++; if (stallReq !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b want 0", stallReq); end
      drive_nop();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_passthrough();
      logic [31:0] opw;
      logic [31:0] d;
      logic [4:0] n;
      logic w;
      @(negedge clk);
      drive(5'h01, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234);
      #1;
      n_cmp++; if ({wbWriteData, wbWriteReg, wbWriteNum, stallReq} !== {32'h1234, 1'b1, 5'd5, 1'b0}) begin n_bad++; $display("FAIL alu_pass got %h/%b/%0d/%b want 1234/1/5/0", wbWriteData, wbWriteReg, wbWriteNum, stallReq); end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         n_cmp++; if (dm_req !== 1'b0) begin n_bad++; $display("FAIL pass_noreq got %b want 0", dm_req); end
         opw = rand_nonmem_op_word(); d = $urandom; n = 5'($urandom_range(0, 31)); w = 1'($urandom_range(0, 1));
         drive(opw[4:0], $urandom, $urandom, n, w, d);
         dm_ack = 1'($urandom_range(0, 1));
         #1;
         n_cmp++; if ({wbWriteData, wbWriteReg, wbWriteNum, stallReq, misalignExc} !== {d, w, n, 1'b0, 1'b0}) begin n_bad++; $display("FAIL pass_rand op=%h got %h/%b/%0d/%b/%b want %h/%b/%0d/0/0", opw[4:0], wbWriteData, wbWriteReg, wbWriteNum, stallReq, misalignExc, d, w, n); end
      end
      dm_ack = 1'b0;
      @(negedge clk);
      n_cmp++; if (dm_req !== 1'b0) begin n_bad++; $display("FAIL pass_noreq_end got %b want 0", dm_req); end
   endtask

   task automatic test_directed();
      run_mem_op(5'h10, 32'h0100_0003, 32'h0, 32'h80FF_FF7F, 2, 5'd7, 1'b1, 32'h0);
      n_cmp++; if (wbWriteData !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_dir got %h want ffffff80", wbWriteData); end
      run_mem_op(5'h11, 32'h0100_0003, 32'h0, 32'h80FF_FF7F, 2, 5'd7, 1'b1, 32'h0);
      n_cmp++; if (wbWriteData !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_dir got %h want 00000080", wbWriteData); end
      run_mem_op(5'h16, 32'h0000_2002, 32'hAAAA_BEEF, 32'h0, 1, 5'd3, 1'b1, 32'h0);
      n_cmp++; if (wbWriteReg !== 1'b0) begin n_bad++; $display("FAIL sh_done_wbreg got %b want 0", wbWriteReg); end
      @(negedge clk);
      drive_nop(); dm_ack = 1'b0;
   endtask

   task automatic test_random_ops();
      logic [31:0] opw;
      logic [31:0] a;
      for (int i = 0; i < 30; i++) begin
         opw = $urandom_range(16, 23);
         a = $urandom & ~(32'(op_size(opw[4:0])) - 32'd1);
         run_mem_op(opw[4:0], a, $urandom, $urandom, $urandom_range(0, 3), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
      end
      @(negedge clk);
      drive_nop(); dm_ack = 1'b0;
   endtask

   task automatic test_back_to_back();
      run_mem_op(5'h17, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 0, 5'd1, 1'b1, 32'h0);
      run_mem_op(5'h14, 32'h0000_0044, 32'h0, 32'h1357_9BDF, 0, 5'd9, 1'b1, 32'h0);
      run_mem_op(5'h12, 32'h0000_0046, 32'h0, 32'hF00F_1234, 0, 5'd2, 1'b1, 32'h0);
      @(negedge clk);
      drive_nop(); dm_ack = 1'b0;
   endtask

   task automatic test_misalign();
      logic [4:0] ops [5];
      logic [31:0] a;
      int k;
      ops = '{5'h12, 5'h13, 5'h16, 5'h14, 5'h17};
      for (int i = 0; i < 10; i++) begin
         k = (i == 0) ? 3 : $urandom_range(0, 4);
         a = (i == 0) ? 32'h0000_2001 : ($urandom | ((k >= 3) ? 32'(1 << $urandom_range(0, 1)) : 32'd1));
         @(negedge clk);
         drive(ops[k], a, $urandom, 5'd4, 1'b1, 32'h0);
         #1;
         n_cmp++; if ({misalignExc, stallReq, wbWriteReg} !== 3'b100) begin n_bad++; $display("FAIL misal op=%h addr=%h got exc/stall/wb=%b want 100", ops[k], a, {misalignExc, stallReq, wbWriteReg}); end
         @(negedge clk);
         drive_nop();
         #1;
         n_cmp++; if ({dm_req, misalignExc} !== 2'b00) begin n_bad++; $display("FAIL misal_after got req/exc=%b want 00", {dm_req, misalignExc}); end
      end
   endtask

   task automatic test_timeout();
      int req_cycles;
      int cyc;
      @(negedge clk);
      drive(5'h17, 32'h0000_3000, 32'h1111_2222, 5'd6, 1'b1, 32'h0);
      dm_ack = 1'b0;
      req_cycles = 0;
      #1;
      for (cyc = 0; cyc < 12 && busErr !== 1'b1; cyc++) begin
         @(negedge clk);
         #1;
         if (dm_req === 1'b1) req_cycles++;
      end
      n_cmp++; if (busErr !== 1'b1) begin n_bad++; $display("FAIL timeout_buserr got %b want 1 (no abort within bound)", busErr); end
      n_cmp++; if (req_cycles !== 4) begin n_bad++; $display("FAIL timeout_req_cycles got %0d want 4", req_cycles); end
      n_cmp++; if ({dm_req, stallReq, wbWriteReg} !== 3'b000) begin n_bad++; $display("FAIL timeout_done got req/stall/wb=%b want 000", {dm_req, stallReq, wbWriteReg}); end
      @(negedge clk);
      drive(5'h02, 32'h0, 32'h0, 5'd8, 1'b1, 32'h5555);
      #1;
      n_cmp++; if ({busErr, stallReq, wbWriteReg, wbWriteData} !== {1'b0, 1'b0, 1'b1, 32'h5555}) begin n_bad++; $display("FAIL timeout_idle got err/stall/wb=%b%b%b data=%h want 001 5555", busErr, stallReq, wbWriteReg, wbWriteData); end
      @(negedge clk);
      n_cmp++; if ({busErr, dm_req} !== 2'b00) begin n_bad++; $display("FAIL timeout_once got err/req=%b want 00", {busErr, dm_req}); end
   endtask

   task automatic test_reset_midtx();
      @(negedge clk);
      drive(5'h14, 32'h0000_5000, 32'h0, 5'd11, 1'b1, 32'h0);
      dm_ack = 1'b0;
      @(negedge clk);
      n_cmp++; if (dm_req !== 1'b1) begin n_bad++; $display("FAIL midtx_req got %b want 1", dm_req); end
      #2 rst = 1'b0;
      #1;
      n_cmp++; if ({dm_req, stallReq} !== 2'b00) begin n_bad++; $display("FAIL midtx_async got req/stall=%b want 00", {dm_req, stallReq}); end
      dm_ack = 1'b1; dm_rdata = 32'hDEAD_DEAD;
      @(negedge clk);
      #2 rst = 1'b1; dm_ack = 1'b0;
      #1;
      n_cmp++; if ({stallReq, dm_req, wbWriteReg} !== 3'b100) begin n_bad++; $display("FAIL midtx_restart_idle got stall/req/wb=%b want 100", {stallReq, dm_req, wbWriteReg}); end
      @(negedge clk);
      n_cmp++; if ({dm_req, dm_addr} !== {1'b1, 32'h0000_5000}) begin n_bad++; $display("FAIL midtx_restart_req got %b/%h want 1/00005000", dm_req, dm_addr); end
      dm_ack = 1'b1; dm_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      dm_ack = 1'b0;
      #1;
      n_cmp++; if ({stallReq, wbWriteReg, wbWriteData} !== {1'b0, 1'b1, 32'h0BAD_F00D}) begin n_bad++; $display("FAIL midtx_done got stall/wb=%b%b data=%h want 01 0badf00d", stallReq, wbWriteReg, wbWriteData); end
      @(negedge clk);
      drive_nop();
   endtask

   initial begin
      drive_nop();
      test_reset();
      test_passthrough();
      test_directed();
      test_misalign();
      test_random_ops();
      test_back_to_back();
      test_timeout();
      test_reset_midtx();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
